// File: rtl/regfile_reader_if.sv
// Decode-to-execute operand fetch bus: instruction in, register-file read port,
// writeback snoop, and the operand bundle out.
interface regfile_reader_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    // decoded instruction from decode
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] rs;
    logic [ADDR_WIDTH-1:0] rt;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  uses_rs;
    logic                  uses_rt;
    logic                  writes_rd;

    // register-file read port
    logic [ADDR_WIDTH-1:0] Read_reg1;
    logic [ADDR_WIDTH-1:0] Read_reg2;
    logic [DATA_WIDTH-1:0] Read_Data1;
    logic [DATA_WIDTH-1:0] Read_Data2;

    // writeback bus shared with the register file
    logic                  RegWrite;
    logic [ADDR_WIDTH-1:0] Write_regs;
    logic [DATA_WIDTH-1:0] Write_Data;

    // operand bundle to execute
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_a;
    logic [DATA_WIDTH-1:0] out_b;
    logic [ADDR_WIDTH-1:0] out_rd;
    logic                  out_wr;
    logic                  sb_err;

    // operand-fetch stage side
    modport slave (
        input  in_valid, rs, rt, rd, uses_rs, uses_rt, writes_rd,
        output in_ready,
        output Read_reg1, Read_reg2,
        input  Read_Data1, Read_Data2,
        input  RegWrite, Write_regs, Write_Data,
        output out_valid, out_a, out_b, out_rd, out_wr, sb_err,
        input  out_ready
    );

    // environment side (decode, register file, execute)
    modport master (
        output in_valid, rs, rt, rd, uses_rs, uses_rt, writes_rd,
        input  in_ready,
        input  Read_reg1, Read_reg2,
        output Read_Data1, Read_Data2,
        output RegWrite, Write_regs, Write_Data,
        input  out_valid, out_a, out_b, out_rd, out_wr, sb_err,
        output out_ready
    );
endinterface

// File: rtl/regfile_reader.sv
// Operand-fetch stage: reads both sources, stalls on RAW / scoreboard-full
// hazards, bypasses same-cycle writeback data, and registers the bundle.
module regfile_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CNT_W      = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_reader_if.slave     bus
);
    localparam int unsigned     NREG    = 1 << ADDR_WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // per-register outstanding-writeback counters; entry 0 is pinned to zero
    logic [CNT_W-1:0]      cnt [NREG];
    logic                  sb_err;

    // output bundle register
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_a;
    logic [DATA_WIDTH-1:0] out_b;
    logic [ADDR_WIDTH-1:0] out_rd;
    logic                  out_wr;

    // combinational decode of the current instruction against the scoreboard
    logic                  wb_live;
    logic                  rs_zero;
    logic                  rt_zero;
    logic                  rd_zero;
    logic                  rs_byp;
    logic                  rt_byp;
    logic                  rs_haz;
    logic                  rt_haz;
    logic                  rd_haz;
    logic                  ready_c;
    logic                  accept;
    logic                  inc_en;
    logic [DATA_WIDTH-1:0] opnd_a;
    logic [DATA_WIDTH-1:0] opnd_b;
    logic [NREG-1:0]       inc_vec;
    logic [NREG-1:0]       dec_vec;

    // register-file read addresses follow the sources directly
    assign bus.Read_reg1 = bus.rs;
    assign bus.Read_reg2 = bus.rt;

    // hazard detection, bypass selection and handshake
    always_comb begin
        wb_live = bus.RegWrite && (bus.Write_regs != '0);
        rs_zero = (bus.rs == '0);
        rt_zero = (bus.rt == '0);
        rd_zero = (bus.rd == '0);

        // bypass only when this writeback retires the last outstanding write
        rs_byp  = wb_live && (bus.Write_regs == bus.rs) && (cnt[bus.rs] == CNT_ONE);
        rt_byp  = wb_live && (bus.Write_regs == bus.rt) && (cnt[bus.rt] == CNT_ONE);

        rs_haz  = bus.uses_rs && !rs_zero && (cnt[bus.rs] != '0) && !rs_byp;
        rt_haz  = bus.uses_rt && !rt_zero && (cnt[bus.rt] != '0) && !rt_byp;
        // a saturated counter may still take an increment if a writeback frees a slot
        rd_haz  = bus.writes_rd && !rd_zero && (cnt[bus.rd] == CNT_MAX)
                  && !(bus.RegWrite && (bus.Write_regs == bus.rd));

        ready_c = (!out_valid || bus.out_ready) && !rs_haz && !rt_haz && !rd_haz;
        accept  = bus.in_valid && ready_c;
        inc_en  = accept && bus.writes_rd && !rd_zero;

        if (rs_zero) begin
            opnd_a = '0;
        end else if (rs_byp) begin
            opnd_a = bus.Write_Data;
        end else begin
            opnd_a = bus.Read_Data1;
        end

        if (rt_zero) begin
            opnd_b = '0;
        end else if (rt_byp) begin
            opnd_b = bus.Write_Data;
        end else begin
            opnd_b = bus.Read_Data2;
        end
    end

    assign bus.in_ready = ready_c;

    // one-hot increment / decrement requests per register
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (inc_en) begin
            inc_vec[bus.rd] = 1'b1;
        end
        if (wb_live) begin
            dec_vec[bus.Write_regs] = 1'b1;
        end
    end

    // scoreboard counters and sticky underflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            cnt[0] <= '0;
            for (int unsigned r = 1; r < NREG; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + CNT_ONE;
                end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                end
            end
            // a writeback with nothing outstanding means decode and writeback disagree
            if (wb_live && (cnt[bus.Write_regs] == '0)) begin
                sb_err <= 1'b1;
            end
        end
    end

    // operand bundle register: load on accept, drop when consumed, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_rd    <= '0;
            out_wr    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_a     <= opnd_a;
            out_b     <= opnd_b;
            out_rd    <= bus.rd;
            out_wr    <= bus.writes_rd && !rd_zero;
        end else if (out_valid && bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_a     = out_a;
    assign bus.out_b     = out_b;
    assign bus.out_rd    = out_rd;
    assign bus.out_wr    = out_wr;
    assign bus.sb_err    = sb_err;

endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader: vector table for single-cycle behaviour,
// hand-written sequences for stalls, saturation, backpressure and reset.
module tb_regfile_reader;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    regfile_reader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    regfile_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        uses_rs;
        logic        uses_rt;
        logic        writes_rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        wb;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        exp_ready;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [4:0]  exp_rd;
        logic        exp_wr;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic urs, input logic urt, input logic wrd,
                               input logic [31:0] rd1, input logic [31:0] rd2);
        bus.in_valid   = 1'b1;
        bus.rs         = rs;
        bus.rt         = rt;
        bus.rd         = rd;
        bus.uses_rs    = urs;
        bus.uses_rt    = urt;
        bus.writes_rd  = wrd;
        bus.Read_Data1 = rd1;
        bus.Read_Data2 = rd2;
    endtask

    task automatic drive_wb(input logic en, input logic [4:0] wreg, input logic [31:0] wdata);
        bus.RegWrite   = en;
        bus.Write_regs = wreg;
        bus.Write_Data = wdata;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.uses_rs   = 1'b0;
        bus.uses_rt   = 1'b0;
        bus.writes_rd = 1'b0;
        bus.rs        = '0;
        bus.rt        = '0;
        bus.rd        = '0;
    endtask

    task automatic check_bundle(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic wr);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".out_a"},     bus.out_a,          a);
        check({tag, ".out_b"},     bus.out_b,          b);
        check({tag, ".out_rd"},    32'(bus.out_rd),    32'(rd));
        check({tag, ".out_wr"},    32'(bus.out_wr),    32'(wr));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // rs rt rd urs urt wrd rd1 rd2 wb wreg wdata | ready a b rd wr
        vt[0] = '{5'd3, 5'd4, 5'd0,  1'b1, 1'b1, 1'b0, 32'h11,   32'h22,   1'b0, 5'd0,  32'h0,
                  1'b1, 32'h11,   32'h22,  5'd0,  1'b0};
        vt[1] = '{5'd0, 5'd0, 5'd0,  1'b1, 1'b1, 1'b0, 32'hFFFF, 32'hEEEE, 1'b1, 5'd0,  32'h1234,
                  1'b1, 32'h0,    32'h0,   5'd0,  1'b0};
        vt[2] = '{5'd6, 5'd8, 5'd10, 1'b1, 1'b1, 1'b1, 32'h66,   32'h88,   1'b0, 5'd0,  32'h0,
                  1'b1, 32'h66,   32'h88,  5'd10, 1'b1};
        vt[3] = '{5'd1, 5'd2, 5'd0,  1'b0, 1'b0, 1'b1, 32'h101,  32'h202,  1'b0, 5'd0,  32'h0,
                  1'b1, 32'h101,  32'h202, 5'd0,  1'b0};
        vt[4] = '{5'd10, 5'd11, 5'd12, 1'b1, 1'b1, 1'b0, 32'hDEAD, 32'h33, 1'b1, 5'd10, 32'hCAFE,
                  1'b1, 32'hCAFE, 32'h33,  5'd12, 1'b0};
        vt[5] = '{5'd10, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h77,   32'h0,    1'b0, 5'd0,  32'h0,
                  1'b1, 32'h77,   32'h0,   5'd0,  1'b0};

        // reset: every output zero while held
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        bus.Read_Data1 = '0;
        bus.Read_Data2 = '0;
        idle();
        drive_wb(1'b0, 5'd0, 32'h0);
        repeat (2) @(negedge clk);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.out_a",     bus.out_a,          32'd0);
        check("rst.out_b",     bus.out_b,          32'd0);
        check("rst.out_rd",    32'(bus.out_rd),    32'd0);
        check("rst.out_wr",    32'(bus.out_wr),    32'd0);
        check("rst.sb_err",    32'(bus.sb_err),    32'd0);
        rst_n = 1'b1;

        // back-to-back vector table: drive at negedge, check bundle one cycle later
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check_bundle($sformatf("vec%0d", i - 1), vt[i-1].exp_a, vt[i-1].exp_b,
                             vt[i-1].exp_rd, vt[i-1].exp_wr);
            end
            drive_instr(vt[i].rs, vt[i].rt, vt[i].rd, vt[i].uses_rs, vt[i].uses_rt,
                        vt[i].writes_rd, vt[i].rd1, vt[i].rd2);
            drive_wb(vt[i].wb, vt[i].wreg, vt[i].wdata);
            #1;
            check($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(vt[i].exp_ready));
        end
        @(negedge clk);
        check_bundle("vec5", vt[5].exp_a, vt[5].exp_b, vt[5].exp_rd, vt[5].exp_wr);
        check("vec.sb_err", 32'(bus.sb_err), 32'd0);
        idle();
        drive_wb(1'b0, 5'd0, 32'h0);

        // RAW on r5: stall until the writeback, then accept with bypassed data
        @(negedge clk);
        drive_instr(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        @(negedge clk);
        drive_instr(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hDEAD, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("raw.stall%0d", k), 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        drive_wb(1'b1, 5'd5, 32'hABCD);
        #1;
        check("raw.release", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check_bundle("raw", 32'hABCD, 32'h0, 5'd0, 1'b0);
        idle();
        drive_wb(1'b0, 5'd0, 32'h0);

        // r7 saturates at three outstanding writes
        @(negedge clk);
        drive_instr(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("sat.acc%0d", k), 32'(bus.in_ready), 32'd1);
            @(negedge clk);
        end
        #1;
        check("sat.full", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        drive_wb(1'b1, 5'd7, 32'h7777);
        #1;
        check("sat.free_slot", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check_bundle("sat", 32'h0, 32'h0, 5'd7, 1'b1);
        drive_wb(1'b0, 5'd0, 32'h0);
        #1;
        check("sat.still_full", 32'(bus.in_ready), 32'd0);
        idle();
        drive_wb(1'b1, 5'd7, 32'h7777);
        repeat (3) @(negedge clk);
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_instr(5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h70, 32'h0);
        #1;
        check("sat.drained", 32'(bus.in_ready), 32'd1);
        check("sat.sb_err", 32'(bus.sb_err), 32'd0);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("drain.out_valid", 32'(bus.out_valid), 32'd0);

        // backpressure: bundle holds for four cycles, next loads on release
        bus.out_ready = 1'b0;
        drive_instr(5'd3, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 32'h55, 32'h66);
        @(negedge clk);
        drive_instr(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 32'h99, 32'hAA);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("bp.ready%0d", k), 32'(bus.in_ready), 32'd0);
            check_bundle($sformatf("bp.hold%0d", k), 32'h55, 32'h66, 5'd0, 1'b0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp.release", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check_bundle("bp.next", 32'h99, 32'hAA, 5'd0, 1'b0);
        idle();
        @(negedge clk);
        check("bp.empty", 32'(bus.out_valid), 32'd0);

        // underflow on r9 is sticky; reset mid-stall clears everything at once
        drive_wb(1'b1, 5'd9, 32'h9);
        @(negedge clk);
        drive_wb(1'b0, 5'd0, 32'h0);
        check("err.set", 32'(bus.sb_err), 32'd1);
        @(negedge clk);
        check("err.sticky", 32'(bus.sb_err), 32'd1);
        drive_instr(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_instr(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h4242, 32'h0);
        #1;
        check("err.stall", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("err.held", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst.out_valid", 32'(bus.out_valid), 32'd0);
        check("mrst.sb_err",    32'(bus.sb_err),    32'd0);
        check("mrst.out_rd",    32'(bus.out_rd),    32'd0);
        check("mrst.out_wr",    32'(bus.out_wr),    32'd0);
        check("mrst.in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("mrst.cnt_cleared", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check_bundle("mrst.after", 32'h4242, 32'h0, 5'd0, 1'b0);
        idle();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
